dark_min_filter3x3: RTL

Spatial minimum filter that consumes the per-pixel dark channel (min of R,G,B) and produces the 3x3-neighbourhood minimum required by dehaze transmission estimation.
Sits directly downstream of the RGB dark-channel stage and upstream of atmospheric-light and transmission estimation.
Uses two on-chip line buffers and a 3-stage pipeline; sync signals are delayed to stay aligned with the data.

---
 rtl/dark_min_filter3x3.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dark_min_filter3x3.sv
// Purpose : 3x3 causal minimum filter over the per-pixel dark channel for dehaze.
// Latency : 3 pixelclk cycles for o_dark, o_hsync, o_vsync and o_de.
// Backpres: none; streaming video timing, one pixel per clock whenever i_de=1.
//
// Ports:
//   pixelclk, reset_n        clock, synchronous active-low reset
//   i_dark/i_de              dark-channel pixel and data enable
//   i_hsync/i_vsync          syncs; i_vsync=1 clears the row count
//   i_bypass                 (only with DARK_MIN_BYPASS_EN) pass i_dark straight through
//   o_dark/o_de              3x3 minimum (0 when o_de=0) and delayed enable
//   o_hsync/o_vsync          syncs delayed to match o_dark
//
// Optional feature macro: DARK_MIN_BYPASS_EN adds the i_bypass input.
// Output slot (r,c) is min over rows r-2..r and cols c-2..c; neighbours
// above/left of the image count as 8'hFF.
module dark_min_filter3x3 #(
  parameter int IMG_WIDTH = 1280,
  parameter int ADDR_W    = 11
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic [7:0] i_dark,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
`ifdef DARK_MIN_BYPASS_EN
  input  logic       i_bypass,
`endif
  output logic [7:0] o_dark,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [7:0]        NEUTRAL = 8'hFF;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // Column / row tracking
  // ---------------------------------------------------------------------------
  logic              de_d;
  logic [ADDR_W-1:0] col;      // address of the next pixel within the line
  logic [1:0]        row;      // 0, 1, or 2 meaning ">=2"
  logic [ADDR_W-1:0] addr;     // address of the pixel arriving this cycle
  logic [1:0]        row_now;

  // The first pixel of a line is always col 0, whatever the blanking length.
  always_comb begin
    addr    = de_d ? col : '0;
    row_now = i_vsync ? 2'd0 : row;
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      de_d <= 1'b0;
      col  <= '0;
      row  <= 2'd0;
    end else begin
      de_d <= i_de;
      if (i_de)
        col <= (addr == COL_MAX) ? addr : addr + ADDR_W'(1);
      if (i_vsync)
        row <= 2'd0;
      else if (de_d && !i_de && row != 2'd2)
        row <= row + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: LB1 = previous line, LB2 = line before that.
  // Read-before-write so LB2 receives LB1's old content for the same column.
  // Contents are never reset; the row count masks stale data instead.
  // ---------------------------------------------------------------------------
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb1_q;
  logic [7:0] lb2_q;

  always_ff @(posedge pixelclk) begin
    lb1_q <= lb1[addr];
    lb2_q <= lb2[addr];
    if (i_de) begin
      lb1[addr] <= i_dark;
      lb2[addr] <= lb1[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // S1: register pixel and side-band alongside the RAM read
  // ---------------------------------------------------------------------------
  logic [7:0]        s1_pix;
  logic              s1_de, s1_hs, s1_vs;
  logic [ADDR_W-1:0] s1_col;
  logic [1:0]        s1_row;
`ifdef DARK_MIN_BYPASS_EN
  logic              s1_byp;
`endif

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      s1_pix <= 8'h00;
      s1_de  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_col <= '0;
      s1_row <= 2'd0;
`ifdef DARK_MIN_BYPASS_EN
      s1_byp <= 1'b0;
`endif
    end else begin
      s1_pix <= i_dark;
      s1_de  <= i_de;
      s1_hs  <= i_hsync;
      s1_vs  <= i_vsync;
      s1_col <= addr;
      s1_row <= row_now;
`ifdef DARK_MIN_BYPASS_EN
      s1_byp <= i_bypass;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // S2: vertical minimum, masking rows above the image top
  // ---------------------------------------------------------------------------
  logic [7:0]        vmin;
  logic [7:0]        s2_vmin;
  logic              s2_de, s2_hs, s2_vs;
  logic [ADDR_W-1:0] s2_col;
`ifdef DARK_MIN_BYPASS_EN
  logic [7:0]        s2_pix;
  logic              s2_byp;
`endif

  always_comb begin
    vmin = min2(s1_pix, min2((s1_row != 2'd0) ? lb1_q : NEUTRAL,
                             s1_row[1]        ? lb2_q : NEUTRAL));
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      s2_vmin <= 8'h00;
      s2_de   <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_col  <= '0;
`ifdef DARK_MIN_BYPASS_EN
      s2_pix  <= 8'h00;
      s2_byp  <= 1'b0;
`endif
    end else begin
      s2_vmin <= vmin;
      s2_de   <= s1_de;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_col  <= s1_col;
`ifdef DARK_MIN_BYPASS_EN
      s2_pix  <= s1_pix;
      s2_byp  <= s1_byp;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // S3: horizontal minimum over the last three column minima of this line.
  // h1/h2 may hold the previous line's tail; the column mask hides it.
  // ---------------------------------------------------------------------------
  logic [7:0] h1, h2;
  logic [7:0] hmin;
  logic [7:0] dark_sel;

  always_comb begin
    hmin = min2(s2_vmin, min2((s2_col != '0)              ? h1 : NEUTRAL,
                              (s2_col[ADDR_W-1:1] != '0) ? h2 : NEUTRAL));
`ifdef DARK_MIN_BYPASS_EN
    dark_sel = s2_byp ? s2_pix : hmin;
`else
    dark_sel = hmin;
`endif
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      h1      <= 8'h00;
      h2      <= 8'h00;
      o_dark  <= 8'h00;
      o_de    <= 1'b0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
    end else begin
      // History keeps updating in bypass so switching back is glitch-free.
      if (s2_de) begin
        h1 <= s2_vmin;
        h2 <= h1;
      end
      o_dark  <= s2_de ? dark_sel : 8'h00;
      o_de    <= s2_de;
      o_hsync <= s2_hs;
      o_vsync <= s2_vs;
    end
  end

endmodule
